// File: rtl/thermo_level_pkg.sv
// Shared types and helpers for the thermometer level sequencer.
package thermo_level_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_HOLD} state_e;

    localparam int                 LEVEL_W   = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd8;

    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] l);
        return (l > LEVEL_MAX) ? LEVEL_MAX : l;
    endfunction

    function automatic logic [7:0] level_to_therm(input logic [LEVEL_W-1:0] l);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = (l > LEVEL_W'(i));
        return t;
    endfunction

endpackage

// File: rtl/thermo_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on the wrap.
module thermo_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = ena & ~clr & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt_q <= '0;
        else if (ena) cnt_q <= cnt_d;
    end

endmodule

// File: rtl/thermo_level_seq.sv
// Animates the thermometer level one step per tick toward a requested target.
// Optional self-sweep mode is enabled with THERMO_LEVEL_SEQ_AUTOSWEEP_EN.
module thermo_level_seq
    import thermo_level_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int HOLD_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
`ifdef THERMO_LEVEL_SEQ_AUTOSWEEP_EN
    input  logic               sweep_en,
`endif
    input  logic               tgt_valid,
    output logic               tgt_ready,
    input  logic [LEVEL_W-1:0] tgt_level,
    output logic [7:0]         therm,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               done
);

    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] tgt_q, tgt_d;
    logic [HW-1:0]      dwell_q, dwell_d;
    logic [7:0]         therm_q;
    logic               done_q, done_d;
    logic               same_q, same_d;

    logic               req_vld;
    logic [LEVEL_W-1:0] req_lvl;
    logic               clr, tick;

    always_comb begin
`ifdef THERMO_LEVEL_SEQ_AUTOSWEEP_EN
        // External requests win; otherwise bounce between the two ends.
        req_vld = tgt_valid | sweep_en;
        req_lvl = tgt_valid ? clamp_level(tgt_level)
                            : ((level_q < LEVEL_MAX) ? LEVEL_MAX : '0);
`else
        req_vld = tgt_valid;
        req_lvl = clamp_level(tgt_level);
`endif
    end

    assign clr = ena & req_vld & (state_q == ST_IDLE) & (req_lvl != level_q);

    thermo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        tgt_d   = tgt_q;
        dwell_d = dwell_q;
        done_d  = same_q;  // a same-level request completes one cycle after acceptance
        same_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    tgt_d = req_lvl;
                    if (req_lvl != level_q) state_d = ST_RAMP;
                    else                    same_d  = 1'b1;
                end
            end
            ST_RAMP: begin
                if (tick) begin
                    if (tgt_q > level_q && level_q < LEVEL_MAX) level_d = level_q + 1'b1;
                    else if (tgt_q < level_q && level_q != '0)  level_d = level_q - 1'b1;
                    if (level_d == tgt_q) begin
                        if (HOLD_TICKS == 0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                            dwell_d = HW'(HOLD_TICKS);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    dwell_d = dwell_q - 1'b1;
                    if (dwell_q == HW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            tgt_q   <= '0;
            dwell_q <= '0;
            therm_q <= 8'h00;
            done_q  <= 1'b0;
            same_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            level_q <= level_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            therm_q <= level_to_therm(level_d);
            done_q  <= done_d;
            same_q  <= same_d;
        end
    end

    assign tgt_ready = (state_q == ST_IDLE);
    assign busy      = ~tgt_ready;
    assign done      = done_q;
    assign level     = level_q;
    assign therm     = therm_q;

endmodule

// File: tb/tb_thermo_level_seq.sv
// Self-checking bench for thermo_level_seq (TICK_DIV=4, HOLD_TICKS=2).
module tb_thermo_level_seq;

    localparam int TD = 4;
    localparam int HT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       tgt_valid = 1'b0;
    logic [3:0] tgt_level = 4'd0;
    logic       tgt_ready, busy, done;
    logic [7:0] therm;
    logic [3:0] level;
`ifdef THERMO_LEVEL_SEQ_AUTOSWEEP_EN
    logic       sweep_en = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    thermo_level_seq #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
`ifdef THERMO_LEVEL_SEQ_AUTOSWEEP_EN
        .sweep_en (sweep_en),
`endif
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .tgt_level(tgt_level),
        .therm    (therm),
        .level    (level),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model: one job = (start, target, enabled edges elapsed since acceptance).
    bit m_act, m_same, m_done;
    int m_start, m_tgt, m_n, m_total, m_lvl;

    function automatic int cur_level();
        int d, s;
        if (!m_act) return m_lvl;
        if (m_same) return m_start;
        d = (m_tgt > m_start) ? m_tgt - m_start : m_start - m_tgt;
        s = m_n / TD;
        if (s > d) s = d;
        return (m_tgt > m_start) ? m_start + s : m_start - s;
    endfunction

    function automatic bit exp_busy();
        return m_act && !m_same && (m_n < m_total);
    endfunction

    task automatic model_reset();
        m_act = 0; m_same = 0; m_done = 0; m_lvl = 0; m_n = 0;
    endtask

    task automatic model_step();
        int  pre_lvl, t, d;
        bit  pre_rdy, req;
        if (!ena) return;
        pre_lvl = cur_level();
        pre_rdy = !exp_busy();
        req = tgt_valid;
        t   = (tgt_level > 8) ? 8 : int'(tgt_level);
`ifdef THERMO_LEVEL_SEQ_AUTOSWEEP_EN
        if (!tgt_valid && sweep_en) begin
            req = 1;
            t   = (pre_lvl < 8) ? 8 : 0;
        end
`endif
        if (m_act) begin
            if (m_n >= m_total) begin
                m_act = 0;
                m_lvl = pre_lvl;
            end else m_n++;
        end
        m_done = m_act && (m_n == m_total);
        if (pre_rdy && req) begin
            d = (t > pre_lvl) ? t - pre_lvl : pre_lvl - t;
            m_act = 1; m_start = pre_lvl; m_tgt = t; m_n = 0;
            m_same  = (d == 0);
            m_total = m_same ? 1 : (d + HT) * TD;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int l;
        l = cur_level();
        chk({tag, ".therm"}, int'(therm), (1 << l) - 1);
        chk({tag, ".level"}, int'(level), l);
        chk({tag, ".busy"},  int'(busy),  int'(exp_busy()));
        chk({tag, ".ready"}, int'(tgt_ready), int'(!exp_busy()));
        chk({tag, ".done"},  int'(done),  int'(m_done));
    endtask

    // One clock: the model follows the edge, the DUT is compared at the falling edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic request(input int lvl);
        tgt_valid = 1'b1;
        tgt_level = 4'(lvl);
        cyc("req");
        tgt_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int cycles);
        cycles = 0;
        while (!done && cycles < max) begin
            cyc(tag);
            cycles++;
        end
        chk({tag, ".done_seen"}, int'(done), 1);
    endtask

    typedef struct {
        int         t;
        logic [7:0] therm;
        logic [3:0] lvl;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int t, c;
        bit saw8;

        vecs[0] = '{1,  8'h00, 4'd0, 1'b1, 1'b0};
        vecs[1] = '{3,  8'h00, 4'd0, 1'b1, 1'b0};
        vecs[2] = '{4,  8'h01, 4'd1, 1'b1, 1'b0};
        vecs[3] = '{7,  8'h01, 4'd1, 1'b1, 1'b0};
        vecs[4] = '{8,  8'h03, 4'd2, 1'b1, 1'b0};
        vecs[5] = '{12, 8'h07, 4'd3, 1'b1, 1'b0};
        vecs[6] = '{19, 8'h07, 4'd3, 1'b1, 1'b0};
        vecs[7] = '{20, 8'h07, 4'd3, 1'b0, 1'b1};
        vecs[8] = '{21, 8'h07, 4'd3, 1'b0, 1'b0};

        // Reset state, before any clock edge
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle");

        // Ramp 0 -> 3 against the timing table
        request(3);
        t = 0;
        for (int i = 0; i < 9; i++) begin
            while (t < vecs[i].t) begin
                cyc("ramp03");
                t++;
            end
            chk("tbl.therm", int'(therm), int'(vecs[i].therm));
            chk("tbl.level", int'(level), int'(vecs[i].lvl));
            chk("tbl.busy",  int'(busy),  int'(vecs[i].busy));
            chk("tbl.done",  int'(done),  int'(vecs[i].done));
        end

        // Clamp 15 -> 8, with an ignored mid-ramp request
        request(15);
        repeat (6) cyc("clamp");
        tgt_valid = 1'b1; tgt_level = 4'd0;
        cyc("midreq");
        tgt_valid = 1'b0;
        wait_done("clamp", 200, c);
        chk("clamp.level", int'(level), 8);
        chk("clamp.therm", int'(therm), 8'hFF);

        // Ramp down to 0
        cyc("gap");
        request(0);
        wait_done("down", 200, c);
        chk("down.therm", int'(therm), 8'h00);

        // Same target: done one cycle later, no motion
        cyc("gap");
        request(5);
        wait_done("to5", 200, c);
        cyc("gap");
        request(5);
        chk("same.t0.done", int'(done), 0);
        cyc("same");
        chk("same.t1.done",  int'(done),  1);
        chk("same.t1.therm", int'(therm), 8'h1F);
        chk("same.t1.busy",  int'(busy),  0);
        cyc("same");

        // Freeze 10 cycles mid-ramp: 5 -> 2 completes at 30 instead of 20
        request(2);
        repeat (6) cyc("frz");
        ena = 1'b0;
        repeat (10) cyc("frz_off");
        ena = 1'b1;
        wait_done("frz", 100, c);
        chk("frz.done_time", 16 + c, 30);

        // Asynchronous reset mid-ramp
        cyc("gap");
        request(8);
        repeat (9) cyc("rst_ramp");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.therm", int'(therm), 0);
        chk("arst.level", int'(level), 0);
        check_all("arst");
        cyc("arst_hold");
        rst_n = 1'b1;
        cyc("arst_rel");

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            tgt_valid = ($urandom_range(0, 3) == 0);
            tgt_level = 4'($urandom_range(0, 15));
            ena       = ($urandom_range(0, 7) != 0);
            cyc("rnd");
        end
        tgt_valid = 1'b0;
        ena = 1'b1;

`ifdef THERMO_LEVEL_SEQ_AUTOSWEEP_EN
        // Autosweep from reset
        @(negedge clk);
        rst_n = 1'b0;
        #1 model_reset();
        sweep_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        saw8 = 0;
        for (int i = 0; i < 250; i++) begin
            cyc("sweep");
            if (level == 4'd8) saw8 = 1;
        end
        chk("sweep.reached8", int'(saw8), 1);
        sweep_en = 1'b0;
`else
        saw8 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
